seg7_axil_regs: RTL

AXI4-Lite slave that is the responder end of the Seg7IP register interface. It holds four 32-bit read/write registers and drives a time-multiplexed 4-digit common-anode 7-segment display from them. The block sits between the PS/VIP AXI4-Lite master and the board display pins.

---
 rtl/seg7_axil_regs_if.sv | 52 +++++
 rtl/seg7_axil_regs.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg7_axil_regs_if.sv
// AXI4-Lite channel bundle for the Seg7IP register slave.
// The master modport is the PS/VIP side and the slave modport is seg7_axil_regs.
interface seg7_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/seg7_axil_regs.sv
// AXI4-Lite slave with four 32-bit registers driving a multiplexed
// 4-digit common-anode 7-segment display.
module seg7_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [15:0] DEFAULT_DIV        = 16'd49999
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    seg7_axil_regs_if.slave   s_axi,
    output logic [6:0]        seg_n,
    output logic              dp_n,
    output logic [3:0]        an_n
);

    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] wmask;
    logic [1:0]  wr_sel, rd_sel;
    logic        wr_accept, rd_accept;
    logic [15:0] scan_cnt;
    logic [1:0]  digit_idx;
    logic        scan_wrap;
    logic        digit_on;
    logic        unused_bits;

    assign wr_sel = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1 -: 2];
    assign rd_sel = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1 -: 2];
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-3:0],
                           s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-3:0]};

    // Idle state already implies !AWREADY && !BVALID (and !ARREADY && !RVALID).
    assign wr_accept = (wr_state == WR_IDLE) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign rd_accept = (rd_state == RD_IDLE) && s_axi.S_AXI_ARVALID;

    assign wmask = {{8{s_axi.S_AXI_WSTRB[3]}}, {8{s_axi.S_AXI_WSTRB[2]}},
                    {8{s_axi.S_AXI_WSTRB[1]}}, {8{s_axi.S_AXI_WSTRB[0]}}};

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (wr_accept) wr_next = WR_ACK;
            WR_ACK:  wr_next = WR_RESP;
            WR_RESP: if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (rd_accept) rd_next = RD_ACK;
            RD_ACK:  rd_next = RD_DATA;
            RD_DATA: if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    assign s_axi.S_AXI_AWREADY = (wr_state == WR_ACK);
    assign s_axi.S_AXI_WREADY  = (wr_state == WR_ACK);
    assign s_axi.S_AXI_BVALID  = (wr_state == WR_RESP);
    assign s_axi.S_AXI_BRESP   = '0;
    assign s_axi.S_AXI_ARREADY = (rd_state == RD_ACK);
    assign s_axi.S_AXI_RVALID  = (rd_state == RD_DATA);
    assign s_axi.S_AXI_RRESP   = '0;
    assign s_axi.S_AXI_RDATA   = rdata;

    // Read data is sampled at the same edge as any write, so a colliding read sees the old value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            regs[0] <= '0;
            regs[1] <= '0;
            regs[2] <= '0;
            regs[3] <= {16'h0, DEFAULT_DIV};
            rdata   <= '0;
        end else begin
            if (wr_accept)
                regs[wr_sel] <= (regs[wr_sel] & ~wmask) | (s_axi.S_AXI_WDATA & wmask);
            if (rd_accept)
                rdata <= regs[rd_sel];
        end
    end

    assign scan_wrap = (scan_cnt >= regs[3][15:0]);

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + 16'd1;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign digit_on = regs[1][digit_idx] && !regs[2][8];

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            seg_n <= '1;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else if (digit_on) begin
            seg_n <= ~hex7(regs[0][{digit_idx, 2'b00} +: 4]);
            dp_n  <= ~regs[2][digit_idx];
            an_n  <= ~(4'b0001 << digit_idx);
        end else begin
            seg_n <= '1;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end
    end

endmodule
